// File: rtl/orb_pkg.sv
// Shared constants and types for the ORB descriptor scheduler.
package orb_pkg;

  localparam int unsigned DESC_W        = 288;

  // Trailer beat field positions; every other trailer bit is zero.
  localparam int unsigned TRL_KEPT_LSB  = 272;
  localparam int unsigned TRL_DROP_LSB  = 256;
  localparam int unsigned TRL_TRUNC_BIT = 255;

  typedef enum logic [1:0] {
    StIdle,
    StCollect,
    StTrail
  } sched_state_e;

endpackage

// File: rtl/orb_desc_fifo.sv
// Synchronous first-word-fall-through FIFO with a registered head.
// A word written into an empty FIFO shows on o_valid/o_rd_data one cycle later.
module orb_desc_fifo #(
  parameter int unsigned P_WIDTH = 289,
  parameter int unsigned P_DEPTH = 64
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic                             i_wr_en,
  input  logic [P_WIDTH-1:0]               i_wr_data,
  input  logic                             i_rd_en,
  output logic                             o_valid,
  output logic [P_WIDTH-1:0]               o_rd_data,
  output logic [$clog2(P_DEPTH + 1)-1:0]   o_count,
  output logic                             o_full,
  output logic                             o_empty
);

  localparam int unsigned PtrW = $clog2(P_DEPTH);
  localparam int unsigned CntW = $clog2(P_DEPTH + 1);

  logic [P_WIDTH-1:0] mem_q [P_DEPTH];
  logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]    count_q, count_d;
  logic [CntW-1:0]    remain;
  logic [P_WIDTH-1:0] dout_q, dout_d;
  logic               dvalid_q, dvalid_d;
  logic               push, pop;

  // Pointer/count update; the head register only ever loads entries that were
  // already stored before this edge, so a same-cycle write never races it.
  always_comb begin
    push     = i_wr_en && (count_q != CntW'(P_DEPTH));
    pop      = i_rd_en && dvalid_q;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    remain   = count_q - CntW'(pop);
    count_d  = remain + CntW'(push);
    dvalid_d = (remain != '0);
    dout_d   = dvalid_d ? mem_q[rd_ptr_d] : '0;
  end

  // Storage array, no reset needed.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= i_wr_data;
    end
  end

  // Pointers, occupancy and head register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
      dvalid_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
    end
  end

  assign o_valid   = dvalid_q;
  assign o_rd_data = dout_q;
  assign o_count   = count_q;
  assign o_full    = (count_q == CntW'(P_DEPTH));
  assign o_empty   = (count_q == '0);

endmodule

// File: rtl/orb_descriptor_scheduler.sv
// Frame scheduler: buffers BRIEF keypoints, enforces a per-frame budget and
// re-emits each frame on a valid/ready stream closed by a count trailer.
module orb_descriptor_scheduler
  import orb_pkg::*;
#(
  parameter int unsigned P_DESC_W        = DESC_W,
  parameter int unsigned P_DEPTH         = 64,
  parameter int unsigned P_MAX_KEYPOINTS = 500
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_desc_start,
  input  logic                i_desc_end,
  input  logic                i_desc_valid,
  input  logic [P_DESC_W-1:0] i_desc_value,
  output logic                o_m_valid,
  input  logic                i_m_ready,
  output logic [P_DESC_W-1:0] o_m_data,
  output logic                o_m_sof,
  output logic                o_m_last,
  output logic [15:0]         o_frames_dropped,
  output logic                o_busy
);

  localparam int unsigned CntW = $clog2(P_DEPTH + 1);
  localparam logic [15:0] MaxKept = 16'(P_MAX_KEYPOINTS);
  // Keypoints stop one short of full so the trailer always has a slot.
  localparam logic [CntW-1:0] KeypointLimit = CntW'(P_DEPTH - 1);

  sched_state_e state_q, state_d;
  logic [15:0]  kept_q, kept_d;
  logic [15:0]  dropped_q, dropped_d;
  logic [15:0]  frames_dropped_q, frames_dropped_d;
  logic         trunc_q, trunc_d;
  logic         restart_q, restart_d;
  logic         sof_pending_q;

  logic                fifo_wr_en;
  logic [P_DESC_W:0]   fifo_wr_data;
  logic                fifo_valid;
  logic [P_DESC_W:0]   fifo_rd_data;
  logic [CntW-1:0]     fifo_count;
  logic                fifo_full;
  logic                fifo_empty;
  logic [P_DESC_W-1:0] trailer;

  // Trailer word built from the frozen counters of the closing frame.
  always_comb begin
    trailer = '0;
    trailer[TRL_KEPT_LSB +: 16] = kept_q;
    trailer[TRL_DROP_LSB +: 16] = dropped_q;
    trailer[TRL_TRUNC_BIT]      = trunc_q;
  end

  // Next-state logic and FIFO write selection.
  always_comb begin
    state_d          = state_q;
    kept_d           = kept_q;
    dropped_d        = dropped_q;
    frames_dropped_d = frames_dropped_q;
    trunc_d          = trunc_q;
    restart_d        = restart_q;
    fifo_wr_en       = 1'b0;
    fifo_wr_data     = '0;

    unique case (state_q)
      StIdle: begin
        if (i_desc_start) begin
          kept_d    = '0;
          dropped_d = '0;
          trunc_d   = 1'b0;
          restart_d = 1'b0;
          state_d   = StCollect;
        end
      end

      StCollect: begin
        if (i_desc_end) begin
          // End wins over a coincident start; the start opens the next frame.
          trunc_d   = 1'b0;
          restart_d = i_desc_start;
          state_d   = StTrail;
        end else if (i_desc_start) begin
          trunc_d   = 1'b1;
          restart_d = 1'b1;
          state_d   = StTrail;
        end else if (i_desc_valid) begin
          if ((kept_q < MaxKept) && (fifo_count < KeypointLimit)) begin
            fifo_wr_en   = 1'b1;
            fifo_wr_data = {1'b0, i_desc_value};
            kept_d       = kept_q + 16'd1;
          end else if (dropped_q != 16'hFFFF) begin
            dropped_d = dropped_q + 16'd1;
          end
        end
      end

      StTrail: begin
        if (i_desc_start && (frames_dropped_q != 16'hFFFF)) begin
          frames_dropped_d = frames_dropped_q + 16'd1;
        end
        if (!fifo_full) begin
          fifo_wr_en   = 1'b1;
          fifo_wr_data = {1'b1, trailer};
          if (restart_q) begin
            kept_d    = '0;
            dropped_d = '0;
            trunc_d   = 1'b0;
            restart_d = 1'b0;
            state_d   = StCollect;
          end else begin
            state_d = StIdle;
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // Control state registers.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q          <= StIdle;
      kept_q           <= '0;
      dropped_q        <= '0;
      frames_dropped_q <= '0;
      trunc_q          <= 1'b0;
      restart_q        <= 1'b0;
    end else begin
      state_q          <= state_d;
      kept_q           <= kept_d;
      dropped_q        <= dropped_d;
      frames_dropped_q <= frames_dropped_d;
      trunc_q          <= trunc_d;
      restart_q        <= restart_d;
    end
  end

  // Read side: the beat after a transferred trailer (or reset) starts a frame.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sof_pending_q <= 1'b1;
    end else if (fifo_valid && i_m_ready) begin
      sof_pending_q <= fifo_rd_data[P_DESC_W];
    end
  end

  orb_desc_fifo #(
    .P_WIDTH (P_DESC_W + 1),
    .P_DEPTH (P_DEPTH)
  ) u_fifo (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_wr_en   (fifo_wr_en),
    .i_wr_data (fifo_wr_data),
    .i_rd_en   (i_m_ready),
    .o_valid   (fifo_valid),
    .o_rd_data (fifo_rd_data),
    .o_count   (fifo_count),
    .o_full    (fifo_full),
    .o_empty   (fifo_empty)
  );

  assign o_m_valid        = fifo_valid;
  assign o_m_data         = fifo_rd_data[P_DESC_W-1:0];
  assign o_m_last         = fifo_rd_data[P_DESC_W];
  assign o_m_sof          = fifo_valid && sof_pending_q;
  assign o_frames_dropped = frames_dropped_q;
  assign o_busy           = (state_q != StIdle) || !fifo_empty;

endmodule

// File: doc/orb_descriptor_scheduler.md
Name: orb_descriptor_scheduler

Overview:
Frame-level scheduler between the BRIEF descriptor stream and the downstream consumer (matcher / DDR writer).
- Input is a non-stallable per-frame stream of start, keypoint, and end beats; each keypoint is 288 b = {descriptor[255:0], Y[15:0], X[15:0]}.
- The block buffers keypoints, enforces a per-frame keypoint budget, and re-emits the frame on a valid/ready stream.
- Every output frame is closed with one trailer beat carrying kept/dropped counts.

Parameters:
P_DESC_W, 288, descriptor beat width.
P_DEPTH, 64, FIFO entries; power of two, ≥4.
P_MAX_KEYPOINTS, 500, max keypoints forwarded per frame.

Ports:
i_clk  in  1  single clock.
i_rst_n  in  1  reset, synchronous, active-low.
i_desc_start  in  1  frame start pulse.
i_desc_end  in  1  frame end pulse; arrives with i_desc_valid=1 and value 0.
i_desc_valid  in  1  keypoint beat valid.
i_desc_value  in  288  keypoint beat.
o_m_valid  out  1  output beat valid.
i_m_ready  in  1  consumer ready.
o_m_data  out  288  descriptor or trailer.
o_m_sof  out  1  first beat of a frame.
o_m_last  out  1  trailer beat.
o_frames_dropped  out  16  saturating count of whole frames discarded.
o_busy  out  1  state≠IDLE or FIFO non-empty or trailer pending.

Behaviour:
- Reset (i_rst_n=0 at a clock edge):
  - FIFO pointers cleared; state IDLE; kept/dropped counters cleared; pending trailer cleared; o_frames_dropped=0.
  - o_m_valid, o_m_sof, o_m_last, o_busy = 0; o_m_data = 0.
  - Mid-frame reset discards all buffered data. Nothing is emitted until the next i_desc_start.
- States: IDLE, COLLECT, TRAIL.
  - IDLE: i_desc_start → clear kept/dropped → COLLECT. All other inputs ignored.
  - COLLECT, beat with valid=1 and end=0 (keypoint):
    - write if kept<P_MAX_KEYPOINTS and occupancy<P_DEPTH-1; then kept++.
    - otherwise dropped++ (16 b, saturating).
  - COLLECT, end=1: the beat is a terminator, never stored. Build trailer (truncated=0) → TRAIL.
  - COLLECT, start=1 (missing end): build trailer with truncated=1 → TRAIL. The new frame's start is remembered (restart flag).
  - Simultaneous start and end in COLLECT: end wins; start is remembered as restart.
  - TRAIL: write the trailer when occupancy<P_DEPTH.
    - then go to COLLECT (with counters cleared) if restart is set, else IDLE.
    - a start received while in TRAIL increments o_frames_dropped; that whole frame is ignored.
- Slot reservation:
  - Occupancy is sampled before the same-cycle read.
  - One slot is reserved for the trailer, so a frame's trailer never waits on its own keypoints.
- Trailer layout (P_DESC_W bits):
  - [287:272] kept count
  - [271:256] dropped count
  - [255] truncated flag
  - all other bits 0
- Output:
  - FIFO is first-word-fall-through. A word written at edge k is visible on o_m_* after edge k+1 if the FIFO was empty.
  - Handshake: a beat transfers when o_m_valid & i_m_ready. o_m_data, o_m_sof, o_m_last are held stable while o_m_valid & !i_m_ready.
  - o_m_last=1 exactly on trailer beats.
  - o_m_sof=1 on the first beat after the previous trailer (or after reset). For a zero-keypoint frame, sof and last are both 1 on the trailer.
  - FIFO entry width is P_DESC_W+1; the extra bit marks a trailer. sof is derived at the read side.
- Simultaneous read and write with the FIFO full or empty must be handled correctly: no word lost and no word duplicated.

Decomposition:
- Package orb_pkg:
  - DESC_W=288
  - trailer field offsets: TRL_KEPT_LSB=272, TRL_DROP_LSB=256, TRL_TRUNC_BIT=255
  - state enum {IDLE, COLLECT, TRAIL}
- Sub-module orb_desc_fifo:
  - synchronous FWFT FIFO, width P_DESC_W+1, depth P_DEPTH
  - outputs occupancy, full, empty

Test Plan:
1. start; 3 keypoints X=16..18, ready=1; end → 3 beats, sof on the first; trailer kept=3, dropped=0, last=1; the end beat (valid=1, value 0) is not emitted as data.
2. P_MAX_KEYPOINTS=4; 6 keypoints → 4 data beats; trailer kept=4, dropped=2.
3. P_DEPTH=8; ready=0 for the whole frame; 10 keypoints; end; then ready=1 → 7 data beats, then trailer kept=7, dropped=3.
4. start then end, no keypoints → single beat with sof=1, last=1, o_m_data all zero.
5. start; 2 keypoints; start; 1 keypoint; end → trailer (kept=2, truncated=1); then frame 2 with sof, 1 data beat, trailer kept=1. Also: a second start issued while the FIFO is full and in TRAIL → o_frames_dropped=1.
6. i_rst_n=0 for one cycle mid-frame with 5 words buffered → next cycle o_m_valid=0, o_busy=0; keypoints without a new start are ignored.
